// File: rtl/avalon_st_arbiter_pkg.sv
// Shared state encodings and Avalon-ST constants
// for the round-robin stream arbiter.
package avalon_st_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int READY_LATENCY = 0;

  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/avalon_st_arbiter_if.sv
// Source-side and sink-side Avalon-ST bundle
// around the round-robin arbiter.
interface avalon_st_arbiter_if #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 8
) ();

  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_ready;
  logic                    out_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic [N_SRC-1:0]        grant;
  logic                    busy;

  modport slave (
    input  src_valid,
    input  src_data,
    input  out_ready,
    output src_ready,
    output out_valid,
    output out_data,
    output grant,
    output busy
  );

  modport master (
    output src_valid,
    output src_data,
    output out_ready,
    input  src_ready,
    input  out_valid,
    input  out_data,
    input  grant,
    input  busy
  );

endinterface

// File: rtl/avalon_st_arbiter_rr_pick.sv
// Combinational round-robin picker: first request
// after the one-hot last winner, wrapping around.
module avalon_st_arbiter_rr_pick #(
  parameter int N_SRC = 3
) (
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] last,
  output logic [N_SRC-1:0] sel,
  output logic             any
);

  localparam int IW = $clog2(N_SRC);

  logic [IW-1:0] lidx;

  always_comb begin
    lidx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (last[i]) lidx = IW'(i);
    end
  end

  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    sel   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      j = IW'((int'(lidx) + i) % N_SRC);
      if (!found && req[j]) begin
        sel[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/avalon_st_arbiter.sv
// Round-robin Avalon-ST arbiter: N sources share one
// sink in bursts of up to BURST_LEN beats.
module avalon_st_arbiter #(
  parameter int N_SRC     = 3,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input logic               clk,
  input logic               resetn,
  avalon_st_arbiter_if.slave bus
);

  import avalon_st_arbiter_pkg::*;

  localparam int CW = cnt_width(BURST_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);
  localparam logic [N_SRC-1:0] LAST_RST =
    {1'b1, {(N_SRC-1){1'b0}}};

  state_t            state_q, state_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic [N_SRC-1:0]  last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_SRC-1:0]  sel;
  logic              any;
  logic              in_grant;
  logic              g_valid;
  logic              beat;
  logic [DATA_W-1:0] g_data;

  avalon_st_arbiter_rr_pick #(
    .N_SRC(N_SRC)
  ) u_rr_pick (
    .req (bus.src_valid),
    .last(last_q),
    .sel (sel),
    .any (any)
  );

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i])
        g_data = g_data | bus.src_data[i*DATA_W +: DATA_W];
    end
  end

  assign in_grant = (state_q == ST_GRANT);
  assign g_valid  = |(bus.src_valid & grant_q);
  assign beat     = in_grant & g_valid & bus.out_ready;

  assign bus.out_valid = in_grant & g_valid;
  assign bus.out_data  = in_grant ? g_data : '0;
  assign bus.src_ready =
    (in_grant && bus.out_ready) ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.busy      = in_grant;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          grant_d = sel;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // An idle granted source gives up the sink at once
        if (!g_valid || (beat && cnt_q == CNT_LAST)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = grant_q;
          cnt_d   = '0;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_avalon_st_arbiter.sv
// Directed bench for the round-robin Avalon-ST arbiter
// (BURST_LEN=4 main instance, BURST_LEN=1 second instance).
module tb_avalon_st_arbiter;

  typedef struct {
    logic        rn;
    logic [2:0]  v;
    logic [23:0] d;
    logic        o;
    logic [2:0]  g;
    logic        ov;
    logic [7:0]  od;
    logic [2:0]  sr;
    logic        bz;
  } vec_t;

  logic clk;
  logic rstn;
  logic rstn1;
  int   checks;
  int   failures;
  vec_t vq[$];

  avalon_st_arbiter_if #(.N_SRC(3), .DATA_W(8)) bus ();
  avalon_st_arbiter_if #(.N_SRC(3), .DATA_W(8)) bus1 ();

  avalon_st_arbiter #(
    .N_SRC(3), .DATA_W(8), .BURST_LEN(4)
  ) u_dut (
    .clk   (clk),
    .resetn(rstn),
    .bus   (bus.slave)
  );

  avalon_st_arbiter #(
    .N_SRC(3), .DATA_W(8), .BURST_LEN(1)
  ) u_dut1 (
    .clk   (clk),
    .resetn(rstn1),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rn, input logic [2:0] v,
    input logic [23:0] d, input logic o,
    input logic [2:0] g, input logic ov,
    input logic [7:0] od, input logic [2:0] sr,
    input logic bz);
    vec_t r;
    r.rn = rn; r.v = v; r.d = d; r.o = o;
    r.g = g; r.ov = ov; r.od = od; r.sr = sr; r.bz = bz;
    return r;
  endfunction

  function automatic vec_t idl(
    input logic rn, input logic [2:0] v,
    input logic [23:0] d, input logic o);
    return mk(rn, v, d, o, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0);
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic chk_main(input string nm, input int idx,
                          input logic [2:0] g, input logic ov,
                          input logic [7:0] od,
                          input logic [2:0] sr,
                          input logic bz);
    chk({nm, ".grant"}, idx, 32'(bus.grant), 32'(g));
    chk({nm, ".out_valid"}, idx, 32'(bus.out_valid), 32'(ov));
    chk({nm, ".out_data"}, idx, 32'(bus.out_data), 32'(od));
    chk({nm, ".src_ready"}, idx, 32'(bus.src_ready), 32'(sr));
    chk({nm, ".busy"}, idx, 32'(bus.busy), 32'(bz));
  endtask

  task automatic chk_b1(input int idx,
                        input logic [2:0] g, input logic ov,
                        input logic [7:0] od,
                        input logic [2:0] sr,
                        input logic bz);
    chk("b1.grant", idx, 32'(bus1.grant), 32'(g));
    chk("b1.out_valid", idx, 32'(bus1.out_valid), 32'(ov));
    chk("b1.out_data", idx, 32'(bus1.out_data), 32'(od));
    chk("b1.src_ready", idx, 32'(bus1.src_ready), 32'(sr));
    chk("b1.busy", idx, 32'(bus1.busy), 32'(bz));
  endtask

  task automatic drv(input logic rn, input logic [2:0] v,
                     input logic [23:0] d, input logic o);
    @(posedge clk);
    #1;
    rstn          = rn;
    bus.src_valid = v;
    bus.src_data  = d;
    bus.out_ready = o;
    @(negedge clk);
  endtask

  task automatic drv1(input logic rn, input logic [2:0] v,
                      input logic [23:0] d, input logic o);
    @(posedge clk);
    #1;
    rstn1          = rn;
    bus1.src_valid = v;
    bus1.src_data  = d;
    bus1.out_ready = o;
    @(negedge clk);
  endtask

  localparam logic [23:0] DALL = 24'hC2B1A0;

  initial begin
    logic [2:0]  oh;
    logic [7:0]  ed;
    logic [23:0] dsh;
    int          gi;
    checks   = 0;
    failures = 0;
    rstn           = 1'b0;
    rstn1          = 1'b0;
    bus.src_valid  = '0;
    bus.src_data   = '0;
    bus.out_ready  = 1'b0;
    bus1.src_valid = '0;
    bus1.src_data  = '0;
    bus1.out_ready = 1'b0;

    // src0 alone: burst of 4, bubble, re-grant, then drop
    vq.push_back(idl(1, 3'b001, 24'hCCBB10, 1));
    vq.push_back(mk(1, 3'b001, 24'hCCBB10, 1, 3'b001, 1, 8'h10, 3'b001, 1));
    vq.push_back(mk(1, 3'b001, 24'hCCBB11, 1, 3'b001, 1, 8'h11, 3'b001, 1));
    vq.push_back(mk(1, 3'b001, 24'hCCBB12, 1, 3'b001, 1, 8'h12, 3'b001, 1));
    vq.push_back(mk(1, 3'b001, 24'hCCBB13, 1, 3'b001, 1, 8'h13, 3'b001, 1));
    vq.push_back(idl(1, 3'b001, 24'hCCBB14, 1));
    vq.push_back(mk(1, 3'b001, 24'hCCBB14, 1, 3'b001, 1, 8'h14, 3'b001, 1));
    vq.push_back(mk(1, 3'b000, 24'hCCBB15, 1, 3'b001, 0, 8'h15, 3'b001, 1));
    vq.push_back(idl(1, 3'b000, 24'hCCBB15, 1));
    // reset, src1 stalls 3 cycles after 2nd beat, then src2
    vq.push_back(idl(0, 3'b000, 24'hC220A0, 1));
    vq.push_back(idl(1, 3'b110, 24'hC220A0, 1));
    vq.push_back(mk(1, 3'b110, 24'hC220A0, 1, 3'b010, 1, 8'h20, 3'b010, 1));
    vq.push_back(mk(1, 3'b110, 24'hC221A0, 1, 3'b010, 1, 8'h21, 3'b010, 1));
    vq.push_back(mk(1, 3'b110, 24'hC222A0, 0, 3'b010, 1, 8'h22, 3'b000, 1));
    vq.push_back(mk(1, 3'b110, 24'hC222A0, 0, 3'b010, 1, 8'h22, 3'b000, 1));
    vq.push_back(mk(1, 3'b110, 24'hC222A0, 0, 3'b010, 1, 8'h22, 3'b000, 1));
    vq.push_back(mk(1, 3'b110, 24'hC222A0, 1, 3'b010, 1, 8'h22, 3'b010, 1));
    vq.push_back(mk(1, 3'b110, 24'hC223A0, 1, 3'b010, 1, 8'h23, 3'b010, 1));
    vq.push_back(idl(1, 3'b110, 24'hC223A0, 1));
    vq.push_back(mk(1, 3'b000, 24'hC224A0, 1, 3'b100, 0, 8'hC2, 3'b100, 1));
    vq.push_back(idl(1, 3'b000, 24'hC224A0, 1));
    // src1 drops after 2 beats; src2 wins over src0
    vq.push_back(idl(1, 3'b010, 24'hC230A0, 1));
    vq.push_back(mk(1, 3'b111, 24'hC230A0, 1, 3'b010, 1, 8'h30, 3'b010, 1));
    vq.push_back(mk(1, 3'b111, 24'hC231A0, 1, 3'b010, 1, 8'h31, 3'b010, 1));
    vq.push_back(mk(1, 3'b101, 24'hC232A0, 1, 3'b010, 0, 8'h32, 3'b010, 1));
    vq.push_back(idl(1, 3'b101, 24'hC232A0, 1));
    vq.push_back(mk(1, 3'b101, 24'hC232A0, 1, 3'b100, 1, 8'hC2, 3'b100, 1));
    // reset mid-burst on src2, then src0 first
    vq.push_back(mk(0, 3'b111, 24'hC232A0, 1, 3'b100, 1, 8'hC2, 3'b100, 1));
    vq.push_back(idl(1, 3'b111, 24'hC232A0, 1));
    vq.push_back(mk(1, 3'b111, 24'hC232A0, 1, 3'b001, 1, 8'hA0, 3'b001, 1));

    drv(1'b0, 3'b000, 24'h0, 1'b1);
    drv(1'b0, 3'b000, 24'h0, 1'b1);
    foreach (vq[i]) begin
      drv(vq[i].rn, vq[i].v, vq[i].d, vq[i].o);
      chk_main("tbl", i, vq[i].g, vq[i].ov, vq[i].od,
               vq[i].sr, vq[i].bz);
    end

    // all three requesting: 001,010,100,001 x 4 beats
    drv(1'b0, 3'b111, DALL, 1'b1);
    drv(1'b1, 3'b111, DALL, 1'b1);
    chk_main("rr_rst", 0, 3'b000, 0, 8'h00, 3'b000, 0);
    for (int r = 0; r < 4; r++) begin
      gi  = r % 3;
      oh  = 3'b001 << gi;
      dsh = DALL >> (8 * gi);
      ed  = dsh[7:0];
      for (int b = 0; b < 4; b++) begin
        drv(1'b1, 3'b111, DALL, 1'b1);
        chk_main("rr", r * 5 + b, oh, 1, ed, oh, 1);
      end
      drv(1'b1, 3'b111, DALL, 1'b1);
      chk_main("rr_gap", r, 3'b000, 0, 8'h00, 3'b000, 0);
    end

    // BURST_LEN=1: one beat per grant, 0,1,2,0,1,2
    drv1(1'b0, 3'b111, DALL, 1'b1);
    drv1(1'b0, 3'b111, DALL, 1'b1);
    drv1(1'b1, 3'b111, DALL, 1'b1);
    chk_b1(0, 3'b000, 0, 8'h00, 3'b000, 0);
    for (int k = 0; k < 6; k++) begin
      gi  = k % 3;
      oh  = 3'b001 << gi;
      dsh = DALL >> (8 * gi);
      ed  = dsh[7:0];
      drv1(1'b1, 3'b111, DALL, 1'b1);
      chk_b1(2 * k + 1, oh, 1, ed, oh, 1);
      drv1(1'b1, 3'b111, DALL, 1'b1);
      chk_b1(2 * k + 2, 3'b000, 0, 8'h00, 3'b000, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_st_arbiter.md
Name: avalon_st_arbiter

Overview:
- Round-robin arbiter sharing one Avalon-ST sink between N Avalon-ST sources; ready latency 0 on both sides.
- Sits between the stream sources (e.g. the 4/5/6 pattern generator and its siblings) and the single downstream consumer.
- Grants one source at a time for a burst of up to BURST_LEN accepted beats, then rotates priority.

Parameters:
- N_SRC, 3, number of requesting sources (2..8).
- DATA_W, 8, data width per source.
- BURST_LEN, 4, maximum accepted beats per grant (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  synchronous active-low reset, sampled on rising edge of clk.
- src_valid  input  N_SRC  per-source valid.
- src_data  input  N_SRC*DATA_W  per-source data, source i at bits [i*DATA_W +: DATA_W].
- src_ready  output  N_SRC  per-source ready (backpressure to sources).
- out_ready  input  1  sink ready.
- out_valid  output  1  muxed valid to sink.
- out_data  output  DATA_W  muxed data to sink.
- grant  output  N_SRC  one-hot current grant, registered; all-zero when idle.
- busy  output  1  high while in GRANT state.

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, grant=0, beat_cnt=0, last_grant=N_SRC-1 (so source 0 wins first). Outputs: out_valid=0, out_data=0, src_ready=0, busy=0. Reset mid-burst aborts the burst; no partial-state retention.
- Beat = out_valid && out_ready in the same cycle (Avalon-ST, ready latency 0).
- States: IDLE, GRANT.
- IDLE: out_valid=0, out_data=0, src_ready=0. If any src_valid=1, select the first asserted index scanning last_grant+1, last_grant+2, ... (wrap modulo N_SRC). Register grant=onehot(sel), beat_cnt=0, go to GRANT. Arbitration latency is 1 cycle from request to grant.
- GRANT (granted index g): out_valid=src_valid[g], out_data=src_data[g], src_ready[g]=out_ready, src_ready of every other source=0. All combinational from the registered grant.
- GRANT, beat with beat_cnt==BURST_LEN-1: release.
- GRANT, beat otherwise: beat_cnt+1.
- GRANT, src_valid[g]=0: release immediately; the source is idle and must not hold the sink.
- Release: state=IDLE, grant=0, last_grant=g, beat_cnt=0. Release always passes through one IDLE cycle, so there is one bubble between grants.
- out_ready=0 while out_valid=1: no beat, beat_cnt holds, grant holds indefinitely. Sources must hold data under Avalon-ST rules.
- Non-granted src_valid is ignored in GRANT and never dropped by the arbiter; those sources see src_ready=0.
- BURST_LEN=1: release after every beat, giving strict per-beat round-robin.
- beat_cnt width is clog2(BURST_LEN)+1; it never exceeds BURST_LEN-1.
- Non-granted data never reaches out_data. out_data=0 whenever state=IDLE.

Decomposition:
- Shared constants include file (avalon_st_defs): state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1, plus the Avalon-ST ready-latency constant (0).
- One natural sub-module: rr_pick, purely combinational. Inputs: req[N_SRC], last[N_SRC] (one-hot). Outputs: onehot sel[N_SRC] and any.
- The arbiter FSM, counter and muxing stay in avalon_st_arbiter.

Test Plan (N_SRC=3, DATA_W=8, BURST_LEN=4 unless stated):
- Only src0 valid, data 0x10,0x11,..., out_ready=1 -> grant=001 one cycle after request; beats 0x10..0x13; one IDLE bubble; src0 re-granted (only requester); busy low only in the bubble.
- All three src_valid held 1, out_ready=1 -> grant sequence 001,010,100,001, each for exactly 4 beats with one-cycle gaps; out_data always matches the granted source.
- src1 granted, out_ready=0 for 3 cycles after its 2nd beat -> out_valid=1 and out_data stable for those 3 cycles; src_ready[1]=0 during stall; total 4 beats still delivered, then grant moves to src2.
- src1 drops src_valid after 2 beats while src0 and src2 request -> released the next edge; next grant=100 (src2), not src0.
- resetn=0 for one edge mid-burst on src2 -> following cycle grant=0, out_valid=0, src_ready=000; after reset with all requesting, src0 is granted first.
- BURST_LEN=1, all three requesting, out_ready=1 -> one beat per grant, order 0,1,2,0,1,2, with a bubble between each.
